// File: rtl/gb_dma_pkg.sv
// Shared definitions for the Game Boy OAM DMA engine: FSM encoding, OAM size,
// echo-RAM remap constants and the latency-pipe tag carried alongside each read.
package gb_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2
  } dma_state_e;

  localparam int         OAM_LEN   = 160;
  localparam logic [7:0] ECHO_BASE = 8'hE0;
  localparam logic [7:0] ECHO_OFFS = 8'h20;

  typedef struct packed {
    logic       valid;
    logic [7:0] idx;
  } dma_tag_t;

  // Pages E0h..FFh mirror work RAM at C0h..DFh.
  function automatic logic [7:0] echo_map(input logic [7:0] page);
    return (page >= ECHO_BASE) ? page - ECHO_OFFS : page;
  endfunction

endpackage

// File: rtl/gb_oam_dma_if.sv
// Control, source-read and OAM-write signals of the OAM DMA engine.
// master = the DMA engine, slave = CPU/memory side driving it.
interface gb_oam_dma_if;

  logic        ce;
  logic        start;
  logic [7:0]  page;
  logic        busy;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;
  logic        oam_wr;

  modport master (
    input  ce, start, page, mem_data,
    output busy, mem_addr, mem_rd, oam_addr, oam_data, oam_wr
  );

  modport slave (
    output ce, start, page, mem_data,
    input  busy, mem_addr, mem_rd, oam_addr, oam_data, oam_wr
  );

endinterface

// File: rtl/gb_dma_delay.sv
// Fixed-depth shift register that carries {valid, idx} of each source read
// until its data returns from memory.
module gb_dma_delay
  import gb_dma_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clock,
  input  logic     reset,
  input  dma_tag_t din,
  output dma_tag_t dout
);

  dma_tag_t stage [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: every stage is cleared, not only the head, so no stale read
      // can surface as an OAM write after reset.
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/gb_oam_dma.sv
// Game Boy OAM DMA engine: on an FF46 write, copies LENGTH bytes from page
// {src_hi,00h} into OAM, one byte per machine cycle, holding busy meanwhile.
module gb_oam_dma
  import gb_dma_pkg::*;
#(
  parameter int LENGTH       = OAM_LEN,
  parameter int READ_LATENCY = 1
) (
  input logic          clock,
  input logic          reset,
  gb_oam_dma_if.master bus
);

  if (LENGTH < 1 || LENGTH > 256) begin : g_len_chk
    $error("gb_oam_dma: LENGTH must be in 1..256");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 200) begin : g_lat_chk
    $error("gb_oam_dma: READ_LATENCY must be in 1..200");
  end

  localparam logic [8:0] LEN_CNT  = 9'(LENGTH);
  localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

  dma_state_e state;
  logic [7:0] src_hi;
  // One spare bit so idx can reach LENGTH=256 without wrapping to 0.
  logic [8:0] idx;
  logic       busy_q;
  logic       oam_wr_q;
  logic [7:0] oam_addr_q;
  logic [7:0] oam_data_q;
  logic [7:0] ce_gap;

  dma_tag_t pipe_in, pipe_out;
  logic     rd_fire;
  logic     done;

  assign rd_fire = bus.ce && (state == XFER) && (idx < LEN_CNT);

  // The final write of this transfer is on the bus now; the idx guard keeps a
  // late write from an aborted transfer from ending the new one.
  assign done = (state == XFER) && (idx == LEN_CNT) && oam_wr_q && (oam_addr_q == LAST_IDX);

  assign pipe_in = '{valid: rd_fire, idx: idx[7:0]};

  gb_dma_delay #(.DEPTH(READ_LATENCY)) u_delay (
    .clock (clock),
    .reset (reset),
    .din   (pipe_in),
    .dout  (pipe_out)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      src_hi     <= '0;
      idx        <= '0;
      busy_q     <= 1'b0;
      oam_wr_q   <= 1'b0;
      oam_addr_q <= '0;
      oam_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees
      // the pre-edge values of state/idx regardless of statement order.
      oam_wr_q <= pipe_out.valid;
      if (pipe_out.valid) begin
        oam_addr_q <= pipe_out.idx;
        oam_data_q <= bus.mem_data;
      end

      if (bus.start) begin
        src_hi <= echo_map(bus.page);
        idx    <= '0;
        state  <= SETUP;
        busy_q <= 1'b1;
      end else begin
        unique case (state)
          IDLE:  ;
          SETUP: if (bus.ce) state <= XFER;
          XFER: begin
            if (rd_fire) idx <= idx + 9'd1;
            if (done) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Clocks since the previous ce, saturating; used only by the spacing assertion.
  always_ff @(posedge clock) begin
    if (reset)                ce_gap <= 8'hFF;
    else if (bus.ce)          ce_gap <= '0;
    else if (ce_gap != 8'hFF) ce_gap <= ce_gap + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset && bus.ce) assert (ce_gap >= 8'(READ_LATENCY));
  end

  assign bus.busy     = busy_q;
  assign bus.mem_rd   = rd_fire;
  assign bus.mem_addr = (state == XFER) ? {src_hi, idx[7:0]} : 16'h0000;
  assign bus.oam_wr   = oam_wr_q;
  assign bus.oam_addr = oam_addr_q;
  assign bus.oam_data = oam_data_q;

endmodule

// File: tb/tb_gb_oam_dma.sv
// Randomised scoreboard bench for gb_oam_dma: a per-M-cycle reference model
// queues expected reads/writes; a negedge monitor checks them cycle-exactly.
module tb_gb_oam_dma;

  localparam int LEN = 160;

  typedef struct {
    int         idx;
    logic [7:0] data;
    int         due;
    bit         last;
  } wr_exp_t;

  logic clock;
  logic reset;
  gb_oam_dma_if bus ();

  gb_oam_dma #(.LENGTH(LEN), .READ_LATENCY(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_wr   = 0;
  bit mon_en = 0;

  logic [7:0]  ram [0:65535];
  logic [15:0] rq[$];
  wr_exp_t     wq[$];

  // Reference model state: 0 idle, 1 waiting for first ce, 2 copying.
  int         m_phase = 0;
  int         m_k     = 0;
  logic [7:0] m_src   = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] src_of(input logic [7:0] p);
    if (p >= 8'hE0) return p - 8'h20;
    return p;
  endfunction

  // One clock of stimulus plus the matching reference-model step.
  task automatic tick(input bit ce_v, input bit st_v, input bit rs_v, input logic [7:0] pg);
    logic [15:0] a;
    @(posedge clock);
    #1;
    bus.ce    = ce_v;
    bus.start = st_v;
    bus.page  = pg;
    reset     = rs_v;
    if (rs_v) begin
      rq.delete();
      wq.delete();
      m_phase = 0;
    end else if (st_v) begin
      m_src   = src_of(pg);
      m_k     = 0;
      m_phase = 1;
      foreach (wq[i]) wq[i].last = 1'b0;
    end else if (ce_v) begin
      if (m_phase == 1) m_phase = 2;
      else if (m_phase == 2 && m_k < LEN) begin
        a = {m_src, 8'(m_k)};
        rq.push_back(a);
        wq.push_back('{idx: m_k, data: ram[a], due: cyc + 2, last: (m_k == LEN - 1)});
        m_k++;
      end
    end
  endtask

  // Issue ce every `period` clocks until the model has issued `stop_k` reads.
  task automatic pump(input int period, input int stop_k);
    int guard;
    guard = 0;
    while (m_k < stop_k && guard < 2000) begin
      repeat (period - 1) tick(0, 0, 0, 8'h00);
      tick(1, 0, 0, 8'h00);
      guard++;
    end
    check("pump_progress", m_k, stop_k);
  endtask

  task automatic finish_xfer(input int period);
    int guard;
    pump(period, LEN);
    guard = 0;
    while (bus.busy && guard < 20) begin
      tick(0, 0, 0, 8'h00);
      guard++;
    end
    check("busy_timeout", bus.busy, 1'b0);
    check("wq_drained", wq.size(), 0);
    repeat (3) tick(0, 0, 0, 8'h00);
  endtask

  task automatic full_xfer(input logic [7:0] pg, input int period);
    n_wr = 0;
    tick(0, 1, 0, pg);
    finish_xfer(period);
    check("write_count", n_wr, LEN);
  endtask

  // Work-RAM model: registered read, data valid one clock after mem_rd,
  // scrambled otherwise so a late consumer sees garbage.
  initial begin
    logic        rd_s;
    logic [15:0] a_s;
    bus.mem_data = '0;
    forever begin
      @(negedge clock);
      rd_s = bus.mem_rd;
      a_s  = bus.mem_addr;
      @(posedge clock);
      #1;
      if (rd_s) bus.mem_data = ram[a_s];
      else      bus.mem_data = 8'($urandom);
    end
  end

  // Scoreboard monitor.
  bit          pend_rise = 0, pend_idle = 0, prev_busy = 0, prev_rst = 1, prev_last_wr = 0;
  always @(negedge clock) begin
    bit          exp_rd, exp_wr, is_last;
    logic [15:0] ea;
    wr_exp_t     e;
    if (mon_en) begin
      exp_rd = (rq.size() != 0);
      check("mem_rd", bus.mem_rd, exp_rd);
      if (exp_rd) begin
        ea = rq.pop_front();
        if (bus.mem_rd) check("mem_addr", bus.mem_addr, ea);
      end

      exp_wr  = (wq.size() != 0) && (wq[0].due == cyc);
      is_last = 1'b0;
      check("oam_wr", bus.oam_wr, exp_wr);
      if (exp_wr) begin
        e = wq.pop_front();
        is_last = e.last;
        if (bus.oam_wr) begin
          check("oam_addr", bus.oam_addr, e.idx);
          check("oam_data", bus.oam_data, e.data);
        end
      end
      if (bus.oam_wr) n_wr++;

      if (pend_rise) check("busy_rise", bus.busy, 1'b1);
      if (pend_idle) check("busy_fall_late", bus.busy, 1'b0);
      if (prev_busy && !bus.busy && !prev_rst) check("busy_fall_early", prev_last_wr, 1'b1);

      pend_rise    = bus.start && !reset;
      pend_idle    = is_last;
      prev_busy    = bus.busy;
      prev_rst     = reset;
      prev_last_wr = bus.oam_wr && (bus.oam_addr == 8'(LEN - 1));
    end
  end

  initial begin
    int period;
    logic [7:0] pg;

    reset     = 1'b1;
    bus.ce    = 1'b0;
    bus.start = 1'b0;
    bus.page  = 8'h00;
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);

    repeat (3) tick(0, 0, 1, 8'h00);
    mon_en = 1;
    tick(0, 0, 0, 8'h00);
    @(negedge clock);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_mem_rd", bus.mem_rd, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 16'h0000);
    check("rst_oam_wr", bus.oam_wr, 1'b0);
    check("rst_oam_addr", bus.oam_addr, 8'h00);
    check("rst_oam_data", bus.oam_data, 8'h00);

    // Plain transfer, ce every 4 clocks.
    full_xfer(8'hC1, 4);

    // Echo boundary and non-remapped neighbour.
    full_xfer(8'hE3, 3);
    full_xfer(8'hDF, 3);
    full_xfer(8'hE0, 2);

    // Restart mid-transfer: in-flight byte 49 still lands, then 160 more.
    n_wr = 0;
    tick(0, 1, 0, 8'hC3);
    pump(4, 50);
    tick(0, 1, 0, 8'hC5);
    finish_xfer(4);
    check("restart_writes", n_wr, 210);

    // Reset at idx=80: read 79 is in the pipe and must be dropped.
    n_wr = 0;
    tick(0, 1, 0, 8'hC7);
    pump(4, 80);
    tick(0, 0, 1, 8'h00);
    tick(0, 0, 0, 8'h00);
    @(negedge clock);
    check("rst_mid_busy", bus.busy, 1'b0);
    check("rst_mid_oam_wr", bus.oam_wr, 1'b0);
    for (int i = 0; i < 10; i++) begin
      repeat (3) tick(0, 0, 0, 8'h00);
      tick(1, 0, 0, 8'h00);
    end
    check("rst_mid_writes", n_wr, 79);
    full_xfer(8'hC4, 4);

    // start coincident with ce: that ce is ignored.
    n_wr = 0;
    repeat (4) tick(0, 0, 0, 8'h00);
    tick(1, 1, 0, 8'hC8);
    finish_xfer(4);
    check("coincident_writes", n_wr, LEN);

    // ce held low for 100 clocks mid-transfer.
    n_wr = 0;
    tick(0, 1, 0, 8'hC2);
    pump(3, 60);
    repeat (100) tick(0, 0, 0, 8'h00);
    @(negedge clock);
    check("hold_busy", bus.busy, 1'b1);
    check("hold_addr", bus.mem_addr, 16'hC23C);
    finish_xfer(3);
    check("hold_writes", n_wr, LEN);

    // Random pages and ce spacings.
    for (int t = 0; t < 4; t++) begin
      pg     = 8'($urandom_range(0, 255));
      period = $urandom_range(2, 6);
      full_xfer(pg, period);
    end

    repeat (5) tick(0, 0, 0, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
